pipeline_exec_controller: RTL and testbench

//  Run controller for the 5-stage MIPS pipeline (IF/ID/EX/MEM/WB). Sits between the debug/host command source and the

---
 rtl/mips_ctrl_pkg.sv | 25 ++
 rtl/exec_cycle_counter.sv | 43 ++++
 rtl/pipeline_exec_controller.sv | 177 +++++++++++++++++
 tb/tb_pipeline_exec_controller.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// mips_ctrl_pkg
//   Shared encodings for the MIPS pipeline run controller. Holds the host
//   command codes, the controller state codes and the default HALT encoding.
//   No ports; imported by pipeline_exec_controller and its testbench.
// -----------------------------------------------------------------------------
package mips_ctrl_pkg;

   // Host command encodings (i_cmd)
   localparam logic [1:0] CMD_NOP  = 2'b00;
   localparam logic [1:0] CMD_RUN  = 2'b01;
   localparam logic [1:0] CMD_STEP = 2'b10;
   localparam logic [1:0] CMD_STOP = 2'b11;

   // Controller state encodings
   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_RUN    = 3'd1;
   localparam logic [2:0] ST_STEP   = 3'd2;
   localparam logic [2:0] ST_DRAIN  = 3'd3;
   localparam logic [2:0] ST_HALTED = 3'd4;

   // Instruction word that terminates the program
   localparam logic [31:0] HALT_WORD_DEFAULT = 32'hFFFF_FFFF;

endpackage

// File: rtl/exec_cycle_counter.sv
// -----------------------------------------------------------------------------
// exec_cycle_counter
//   Saturating up-counter of executed pipeline cycles. Counts once per clock
//   while enabled and sticks at all-ones instead of wrapping.
// Ports
//   i_clk    clock
//   i_clr_n  synchronous clear, active low
//   i_en     count enable (one increment per enabled cycle)
//   o_count  current count (registered)
// -----------------------------------------------------------------------------
module exec_cycle_counter #(
   parameter int NB = 32
) (
   input  logic          i_clk,
   input  logic          i_clr_n,
   input  logic          i_en,
   output logic [NB-1:0] o_count
);

   logic [NB-1:0] count_q, count_d;

   always_comb begin
      // NOTE: assign a default before any condition so no path leaves the
      // signal unassigned; otherwise synthesis infers a latch.
      count_d = count_q;
      if (i_en && (count_q != '1)) begin
         count_d = count_q + NB'(1);
      end
   end

   // NOTE: sequential state uses non-blocking (<=) assignments so every flop
   // samples its pre-edge value regardless of statement order.
   always_ff @(posedge i_clk) begin
      if (!i_clr_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign o_count = count_q;

endmodule

// File: rtl/pipeline_exec_controller.sv
// -----------------------------------------------------------------------------
// pipeline_exec_controller
//   Run controller for the 5-stage MIPS pipeline. Sequences RUN / STEP / STOP
//   from the host, detects the HALT word at IF, stops fetch, drains the
//   in-flight instructions and then freezes the pipeline until reset.
//   Optional watchdog: define EXEC_WATCHDOG_EN to halt after MAX_CYCLES
//   enabled cycles in RUN/DRAIN and raise o_timeout.
// Ports
//   i_clk          clock
//   i_rst          synchronous reset, active low
//   i_cmd_valid    host command present
//   i_cmd          01 RUN, 10 STEP, 11 STOP, 00 NOP
//   o_cmd_ready    command accepted when i_cmd_valid & o_cmd_ready
//   i_instruction  instruction currently at IF output
//   o_fetch_en     enables PC and IF/ID register (combinational)
//   o_pipe_en      enables ID/EX, EX/MEM, MEM/WB and RF write (combinational)
//   o_busy         state is RUN, STEP or DRAIN
//   o_halted       state is HALTED
//   o_timeout      watchdog fired, sticky until reset
//   o_cycle_count  saturating count of cycles with o_pipe_en=1
// -----------------------------------------------------------------------------
module pipeline_exec_controller
   import mips_ctrl_pkg::*;
#(
   parameter int              LEN        = 32,
   parameter int              NB_CYCLES  = 32,
   parameter int              NB_DRAIN   = 4,
   parameter logic [LEN-1:0]  HALT_WORD  = LEN'(HALT_WORD_DEFAULT),
   parameter logic [31:0]     MAX_CYCLES = 32'd100000
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_cmd_valid,
   input  logic [1:0]           i_cmd,
   output logic                 o_cmd_ready,
   input  logic [LEN-1:0]       i_instruction,
   output logic                 o_fetch_en,
   output logic                 o_pipe_en,
   output logic                 o_busy,
   output logic                 o_halted,
   output logic                 o_timeout,
   output logic [NB_CYCLES-1:0] o_cycle_count
);

   localparam int DRW = (NB_DRAIN > 1) ? $clog2(NB_DRAIN) : 1;

   logic [2:0]           state_q, state_d;
   logic [DRW-1:0]       drain_cnt_q, drain_cnt_d;
   logic                 cmd_ready_q, cmd_ready_d;
   logic                 busy_q, busy_d;
   logic                 halted_q, halted_d;
   logic                 executing;
   logic                 halt_seen;
   logic                 cmd_acc;
   logic                 wd_fire;
   logic [NB_CYCLES-1:0] cycle_count;

   // Enables are decoded straight from state so the stage registers see them
   // in the same cycle; fetch is withheld the cycle the HALT word is at IF so
   // the HALT itself never advances the PC.
   assign executing  = (state_q == ST_RUN) || (state_q == ST_STEP);
   assign halt_seen  = executing && (i_instruction == HALT_WORD);
   assign o_fetch_en = executing && !halt_seen;
   assign o_pipe_en  = executing || (state_q == ST_DRAIN);
   assign cmd_acc    = i_cmd_valid && cmd_ready_q;

   exec_cycle_counter #(
      .NB (NB_CYCLES)
   ) u_cycle_counter (
      .i_clk   (i_clk),
      .i_clr_n (i_rst),
      .i_en    (o_pipe_en),
      .o_count (cycle_count)
   );

   assign o_cycle_count = cycle_count;

`ifdef EXEC_WATCHDOG_EN
   logic timeout_q, timeout_d;

   // Fires on the enabled cycle that takes the count to MAX_CYCLES.
   assign wd_fire   = ((state_q == ST_RUN) || (state_q == ST_DRAIN)) &&
                      (cycle_count == NB_CYCLES'(MAX_CYCLES - 32'd1));
   assign timeout_d = timeout_q | wd_fire;

   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         timeout_q <= 1'b0;
      end else begin
         timeout_q <= timeout_d;
      end
   end

   assign o_timeout = timeout_q;
`else
   logic unused_max_cycles;

   assign wd_fire           = 1'b0;
   assign o_timeout         = 1'b0;
   assign unused_max_cycles = ^MAX_CYCLES;
`endif

   always_comb begin
      state_d     = state_q;
      drain_cnt_d = drain_cnt_q;

      case (state_q)
         ST_IDLE: begin
            if (cmd_acc && (i_cmd == CMD_RUN)) begin
               state_d = ST_RUN;
            end else if (cmd_acc && (i_cmd == CMD_STEP)) begin
               state_d = ST_STEP;
            end
         end
         // Priority: watchdog, then HALT, then STOP.
         ST_RUN: begin
            if (wd_fire) begin
               state_d = ST_HALTED;
            end else if (halt_seen) begin
               state_d     = ST_DRAIN;
               drain_cnt_d = DRW'(NB_DRAIN - 1);
            end else if (cmd_acc && (i_cmd == CMD_STOP)) begin
               state_d = ST_IDLE;
            end
         end
         ST_STEP: begin
            if (halt_seen) begin
               state_d     = ST_DRAIN;
               drain_cnt_d = DRW'(NB_DRAIN - 1);
            end else begin
               state_d = ST_IDLE;
            end
         end
         // NB_DRAIN cycles here (count NB_DRAIN-1 down to 0) flush ID..WB.
         ST_DRAIN: begin
            if (wd_fire || (drain_cnt_q == '0)) begin
               state_d = ST_HALTED;
            end else begin
               drain_cnt_d = drain_cnt_q - DRW'(1);
            end
         end
         ST_HALTED: begin
            state_d = ST_HALTED;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Status outputs are registered from the next state so they line up
      // with state_q and never glitch.
      cmd_ready_d = (state_d == ST_IDLE) || (state_d == ST_RUN);
      busy_d      = (state_d == ST_RUN) || (state_d == ST_STEP) || (state_d == ST_DRAIN);
      halted_d    = (state_d == ST_HALTED);
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         state_q     <= ST_IDLE;
         drain_cnt_q <= '0;
         cmd_ready_q <= 1'b1;
         busy_q      <= 1'b0;
         halted_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         drain_cnt_q <= drain_cnt_d;
         cmd_ready_q <= cmd_ready_d;
         busy_q      <= busy_d;
         halted_q    <= halted_d;
      end
   end

   assign o_cmd_ready = cmd_ready_q;
   assign o_busy      = busy_q;
   assign o_halted    = halted_q;

endmodule

// File: tb/tb_pipeline_exec_controller.sv
// -----------------------------------------------------------------------------
// tb_pipeline_exec_controller
//   Directed bench for pipeline_exec_controller. Stimulus pushes one expected
//   record per cycle in which the pipeline should be enabled; a monitor on the
//   falling edge pops a record whenever o_pipe_en is high and compares
//   o_fetch_en and the pre-increment o_cycle_count. Status outputs are
//   checked directly from the stimulus. Build with +define+EXEC_WATCHDOG_EN
//   to exercise the watchdog.
// -----------------------------------------------------------------------------
module tb_pipeline_exec_controller;
   import mips_ctrl_pkg::*;

   localparam logic [31:0] HALT = 32'hFFFF_FFFF;

   typedef struct packed {
      logic        fetch;
      logic [31:0] count;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cmd_valid;
   logic [1:0]  cmd;
   logic        cmd_ready;
   logic [31:0] instr;
   logic        fetch_en;
   logic        pipe_en;
   logic        busy;
   logic        halted;
   logic        timeout;
   logic [31:0] cycle_count;

   exp_t sb_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   bit   mon_on  = 1'b0;

   pipeline_exec_controller #(
      .LEN        (32),
      .NB_CYCLES  (32),
      .NB_DRAIN   (4),
      .HALT_WORD  (HALT),
      .MAX_CYCLES (32'd8)
   ) dut (
      .i_clk         (clk),
      .i_rst         (rst_n),
      .i_cmd_valid   (cmd_valid),
      .i_cmd         (cmd),
      .o_cmd_ready   (cmd_ready),
      .i_instruction (instr),
      .o_fetch_en    (fetch_en),
      .o_pipe_en     (pipe_en),
      .o_busy        (busy),
      .o_halted      (halted),
      .o_timeout     (timeout),
      .o_cycle_count (cycle_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_en(input logic f, input int c);
      exp_t e;
      e.fetch = f;
      e.count = 32'(c);
      sb_q.push_back(e);
   endtask

   task automatic send_cmd(input logic [1:0] c);
      cmd_valid = 1'b1;
      cmd       = c;
      tick();
      cmd_valid = 1'b0;
      cmd       = CMD_NOP;
   endtask

   task automatic do_reset();
      rst_n     = 1'b0;
      cmd_valid = 1'b0;
      cmd       = CMD_NOP;
      instr     = 32'h0;
      tick();
      rst_n = 1'b1;
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_busy"},  32'(busy),      32'd0);
      check({tag, "_ready"}, 32'(cmd_ready), 32'd1);
      check({tag, "_fetch"}, 32'(fetch_en),  32'd0);
      check({tag, "_pipe"},  32'(pipe_en),   32'd0);
   endtask

   // Monitor: every enabled cycle must match the next queued expectation.
   always @(negedge clk) begin
      if (mon_on) begin
         if (pipe_en !== 1'b0) begin
            if (sb_q.size() == 0) begin
               check("unexpected_pipe_en", 32'(pipe_en), 32'd0);
            end else begin
               exp_t e;
               e = sb_q.pop_front();
               check("mon_fetch_en", 32'(fetch_en), 32'(e.fetch));
               check("mon_cycle_count", cycle_count, e.count);
            end
         end else begin
            check("mon_fetch_idle", 32'(fetch_en), 32'd0);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "tb timeout");
   end

   initial begin
      rst_n     = 1'b0;
      cmd_valid = 1'b0;
      cmd       = CMD_NOP;
      instr     = 32'h0;
      tick();
      tick();
      rst_n = 1'b1;
      mon_on = 1'b1;

      // Reset state
      check_idle("reset");
      check("reset_halted",  32'(halted),  32'd0);
      check("reset_timeout", 32'(timeout), 32'd0);
      check("reset_count",   cycle_count,  32'd0);

      // 1. RUN for 10 non-HALT words, then STOP (accept cycle still enabled)
      send_cmd(CMD_RUN);
      for (int i = 0; i < 10; i++) begin
         check("t1_busy",  32'(busy),      32'd1);
         check("t1_ready", 32'(cmd_ready), 32'd1);
         instr = 32'h2000_0000 + 32'(i);
         expect_en(1'b1, i);
         tick();
      end
      check("t1_count10", cycle_count, 32'd10);
      expect_en(1'b1, 10);
      send_cmd(CMD_STOP);
      check_idle("t1_stopped");
      check("t1_count11", cycle_count, 32'd11);
      tick();
      check("t1_queue", 32'(sb_q.size()), 32'd0);

      // 2. RUN, HALT on the sixth cycle, drain 4, then HALTED with count 10
      do_reset();
      check("t2_count_clr", cycle_count, 32'd0);
      send_cmd(CMD_RUN);
      for (int i = 0; i < 5; i++) begin
         instr = 32'h0100_0000 + 32'(i);
         expect_en(1'b1, i);
         tick();
      end
      instr = HALT;
      expect_en(1'b0, 5);
      tick();
      instr = 32'h0;
      check("t2_drain_ready", 32'(cmd_ready), 32'd0);
      check("t2_drain_busy",  32'(busy),      32'd1);
      for (int i = 6; i < 10; i++) begin
         expect_en(1'b0, i);
         tick();
      end
      check("t2_halted", 32'(halted),  32'd1);
      check("t2_busy",   32'(busy),    32'd0);
      check("t2_ready",  32'(cmd_ready), 32'd0);
      tick();
      tick();
      check("t2_count", cycle_count, 32'd10);
      check("t2_queue", 32'(sb_q.size()), 32'd0);

      // 3. Three STEPs with idle gaps; a RUN during a step is dropped
      do_reset();
      for (int i = 0; i < 3; i++) begin
         tick();
         tick();
         send_cmd(CMD_STEP);
         check("t3_step_ready", 32'(cmd_ready), 32'd0);
         check("t3_step_busy",  32'(busy),      32'd1);
         expect_en(1'b1, i);
         if (i == 1) begin
            send_cmd(CMD_RUN);
         end else begin
            tick();
         end
         check_idle("t3_after_step");
      end
      tick();
      tick();
      check("t3_count", cycle_count, 32'd3);
      check("t3_queue", 32'(sb_q.size()), 32'd0);

      // 4. STOP together with HALT -> DRAIN; RUN while HALTED ignored
      do_reset();
      send_cmd(CMD_RUN);
      expect_en(1'b1, 0);
      tick();
      expect_en(1'b1, 1);
      tick();
      instr = HALT;
      expect_en(1'b0, 2);
      send_cmd(CMD_STOP);
      instr = 32'h0;
      check("t4_drain_busy",  32'(busy),      32'd1);
      check("t4_drain_ready", 32'(cmd_ready), 32'd0);
      for (int i = 3; i < 7; i++) begin
         expect_en(1'b0, i);
         tick();
      end
      check("t4_halted", 32'(halted), 32'd1);
      check("t4_run_ready", 32'(cmd_ready), 32'd0);
      send_cmd(CMD_RUN);
      tick();
      check("t4_still_halted", 32'(halted), 32'd1);
      check("t4_not_busy",     32'(busy),   32'd0);
      check("t4_count",        cycle_count, 32'd7);
      check("t4_queue", 32'(sb_q.size()), 32'd0);

      // 5. Reset asserted mid-DRAIN
      do_reset();
      send_cmd(CMD_RUN);
      expect_en(1'b1, 0);
      tick();
      instr = HALT;
      expect_en(1'b0, 1);
      tick();
      instr = 32'h0;
      expect_en(1'b0, 2);
      tick();
      // The reset cycle itself is still decoded from DRAIN.
      expect_en(1'b0, 3);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      check_idle("t5_after_reset");
      check("t5_halted", 32'(halted), 32'd0);
      check("t5_count",  cycle_count, 32'd0);
      check("t5_queue", 32'(sb_q.size()), 32'd0);

      // 6. Watchdog with MAX_CYCLES=8
      do_reset();
      send_cmd(CMD_RUN);
      instr = 32'h0000_0020;
`ifdef EXEC_WATCHDOG_EN
      for (int i = 0; i < 8; i++) begin
         expect_en(1'b1, i);
         tick();
      end
      check("t6_halted",  32'(halted),  32'd1);
      check("t6_timeout", 32'(timeout), 32'd1);
      check("t6_busy",    32'(busy),    32'd0);
      tick();
      tick();
      check("t6_count", cycle_count, 32'd8);
      do_reset();
      check("t6_timeout_clr", 32'(timeout), 32'd0);
`else
      for (int i = 0; i < 12; i++) begin
         expect_en(1'b1, i);
         tick();
      end
      check("t6_busy",    32'(busy),    32'd1);
      check("t6_timeout", 32'(timeout), 32'd0);
      check("t6_halted",  32'(halted),  32'd0);
      check("t6_count",   cycle_count,  32'd12);
      expect_en(1'b1, 12);
      send_cmd(CMD_STOP);
      check_idle("t6_stopped");
`endif
      tick();
      check("t6_queue", 32'(sb_q.size()), 32'd0);

      mon_on = 1'b0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
